spi_master_sequencer: RTL and testbench

//  Transfer sequencer for the SPI master. Produces M_BaudRate and idle for the SCK control block,

---
 rtl/spi_seq_if.sv | 45 ++++
 rtl/spi_master_sequencer.sv | 172 +++++++++++++++++
 tb/tb_spi_master_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_seq_if.sv
// Handshake and status bundle between the SPI transfer sequencer and its controller / SCK block.
// Controller drives start/clk_div; the sequencer drives the baud phase, framing and strobes.
interface spi_seq_if #(
  parameter int BITS      = 8,
  parameter int DIV_WIDTH = 8
);
  localparam int CNT_W = $clog2(BITS + 1);

  logic                 start;
  logic [DIV_WIDTH-1:0] clk_div;
  logic                 M_BaudRate;
  logic                 idle;
  logic                 SS_n;
  logic                 busy;
  logic                 done;
  logic                 baud_rise_stb;
  logic                 baud_fall_stb;
  logic [CNT_W-1:0]     bit_cnt;

  modport master (
    output start,
    output clk_div,
    input  M_BaudRate,
    input  idle,
    input  SS_n,
    input  busy,
    input  done,
    input  baud_rise_stb,
    input  baud_fall_stb,
    input  bit_cnt
  );

  modport slave (
    input  start,
    input  clk_div,
    output M_BaudRate,
    output idle,
    output SS_n,
    output busy,
    output done,
    output baud_rise_stb,
    output baud_fall_stb,
    output bit_cnt
  );
endinterface

// File: rtl/spi_master_sequencer.sv
// SPI master transfer sequencer: frames one BITS-bit transfer as SETUP / XFER / HOLD half-periods
// and emits the baud phase, idle gating, slave select, handshakes and edge strobes, all registered.
module spi_master_sequencer #(
  parameter int BITS      = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  spi_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIV_WIDTH-1:0] r_div_q;
  logic [DIV_WIDTH-1:0] w_div_nxt;
  logic [DIV_WIDTH-1:0] r_hp_cnt;
  logic [DIV_WIDTH-1:0] w_hp_nxt;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [CNT_W-1:0]     w_bit_nxt;
  logic                 r_baud;
  logic                 w_baud_nxt;
  logic                 r_idle;
  logic                 w_idle_nxt;
  logic                 r_ss_n;
  logic                 w_ss_n_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_rise_stb;
  logic                 w_rise_nxt;
  logic                 r_fall_stb;
  logic                 w_fall_nxt;
  logic                 w_boundary;
  logic                 w_last_bit;

  // A half-period ends on the cycle the counter reaches the latched divider.
  assign w_boundary = (r_hp_cnt == r_div_q);
  assign w_last_bit = (r_bit_cnt == CNT_W'(BITS - 1));

  // Next-state and next-output decode; every output is computed here and registered below.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_q;
    w_bit_nxt   = r_bit_cnt;
    w_baud_nxt  = r_baud;
    w_idle_nxt  = r_idle;
    w_ss_n_nxt  = r_ss_n;
    w_done_nxt  = 1'b0;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (w_boundary) begin
      w_hp_nxt = {DIV_WIDTH{1'b0}};
    end else begin
      w_hp_nxt = r_hp_cnt + DIV_WIDTH'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_hp_nxt   = {DIV_WIDTH{1'b0}};
        w_baud_nxt = 1'b0;
        w_idle_nxt = 1'b1;
        if (bus.start) begin
          w_state_nxt = S_SETUP;
          w_div_nxt   = bus.clk_div;
          w_bit_nxt   = {CNT_W{1'b0}};
          w_ss_n_nxt  = 1'b0;
        end else begin
          w_ss_n_nxt  = 1'b1;
        end
      end

      S_SETUP: begin
        if (w_boundary) begin
          w_state_nxt = S_XFER;
          w_baud_nxt  = 1'b0;
          w_idle_nxt  = 1'b0;
        end else begin
          w_state_nxt = S_SETUP;
        end
      end

      S_XFER: begin
        if (w_boundary) begin
          w_baud_nxt = ~r_baud;
          if (!r_baud) begin
            w_rise_nxt = 1'b1;
          end else begin
            // A falling phase completes one bit; the BITS-th fall closes the transfer.
            w_fall_nxt = 1'b1;
            w_bit_nxt  = r_bit_cnt + CNT_W'(1);
            if (w_last_bit) begin
              w_state_nxt = S_HOLD;
              w_idle_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_XFER;
            end
          end
        end else begin
          w_state_nxt = S_XFER;
        end
      end

      S_HOLD: begin
        if (w_boundary) begin
          w_state_nxt = S_IDLE;
          w_ss_n_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_hp_nxt    = {DIV_WIDTH{1'b0}};
        w_bit_nxt   = {CNT_W{1'b0}};
        w_baud_nxt  = 1'b0;
        w_idle_nxt  = 1'b1;
        w_ss_n_nxt  = 1'b1;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_div_q    <= {DIV_WIDTH{1'b0}};
      r_hp_cnt   <= {DIV_WIDTH{1'b0}};
      r_bit_cnt  <= {CNT_W{1'b0}};
      r_baud     <= 1'b0;
      r_idle     <= 1'b1;
      r_ss_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rise_stb <= 1'b0;
      r_fall_stb <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div_q    <= w_div_nxt;
      r_hp_cnt   <= w_hp_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_baud     <= w_baud_nxt;
      r_idle     <= w_idle_nxt;
      r_ss_n     <= w_ss_n_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_rise_stb <= w_rise_nxt;
      r_fall_stb <= w_fall_nxt;
    end
  end

  assign bus.M_BaudRate    = r_baud;
  assign bus.idle          = r_idle;
  assign bus.SS_n          = r_ss_n;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.baud_rise_stb = r_rise_stb;
  assign bus.baud_fall_stb = r_fall_stb;
  assign bus.bit_cnt       = r_bit_cnt;
endmodule

// File: tb/tb_spi_master_sequencer.sv
// Self-checking bench for spi_master_sequencer: every cycle of each frame is compared against
// an arithmetic timeline model derived from the half-period rules.
module tb_spi_master_sequencer;
  localparam int B  = 8;
  localparam int DW = 8;
  localparam int CW = $clog2(B + 1);
  localparam int VW = 7 + CW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  spi_seq_if #(.BITS(B), .DIV_WIDTH(DW)) bus ();

  spi_master_sequencer #(.BITS(B), .DIV_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Vector layout: {baud, idle, ss_n, busy, done, rise, fall, bit_cnt}
  function automatic logic [VW-1:0] idle_vec(input int bc);
    return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CW'(bc)};
  endfunction

  // Expected outputs in cycle r of a frame (cycle 1 follows the accepting edge), half-period h.
  function automatic logic [VW-1:0] model(input int r, input int h);
    int   p;
    int   k;
    logic on_edge;
    logic baud;
    logic idl;
    logic rise;
    logic fall;
    p = (2 * B + 2) * h + 1;
    if (r > p) return idle_vec(B);
    if (r == p) return {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CW'(B)};
    k = (r > h) ? (r - h - 1) / h : -1;
    if (k > 2 * B) k = 2 * B;
    on_edge = (r > h) && (((r - h - 1) % h) == 0);
    baud    = (k >= 0) && (k < 2 * B) && (k % 2 == 1);
    idl     = !((k >= 0) && (k < 2 * B));
    rise    = on_edge && (k % 2 == 1) && (k < 2 * B);
    fall    = on_edge && (k >= 2) && (k % 2 == 0);
    return {baud, idl, 1'b0, 1'b1, 1'b0, rise, fall, CW'((k < 0) ? 0 : k / 2)};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {bus.M_BaudRate, bus.idle, bus.SS_n, bus.busy, bus.done,
            bus.baud_rise_stb, bus.baud_fall_stb, bus.bit_cnt};
  endfunction

  // Runs nfr frames with divider d; hold keeps start high throughout; inj>0 pulses start
  // and rewrites clk_div to 5 from that cycle while the frame is in flight.
  task automatic frame_run(input int d, input int nfr, input bit hold, input int inj,
                           input string nm);
    int             h;
    int             p;
    int             total;
    int             r;
    int             ndone;
    int             lead [4];
    int             trail [4];
    logic [3:0]     sck;
    logic           cpol;
    logic           nsck;
    logic [VW-1:0]  act;
    logic [VW-1:0]  exp;
    h     = d + 1;
    p     = (2 * B + 2) * h + 1;
    total = hold ? nfr * p : p + 6;
    ndone = 0;
    for (int m = 0; m < 4; m++) begin
      lead[m]  = 0;
      trail[m] = 0;
      sck[m]   = (m >= 2);
    end
    @(posedge clk); #1;
    bus.clk_div = DW'(d);
    bus.start   = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    for (int rel = 1; rel <= total; rel++) begin
      @(negedge clk);
      r   = hold ? ((rel - 1) % p) + 1 : rel;
      exp = model(r, h);
      act = act_vec();
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL %s d=%0d cyc=%0d got=%b exp=%b", nm, d, rel, act, exp);
      end
      if (bus.done === 1'b1) ndone++;
      // SCK as the SCK block derives it, for CPOL=m[1]; CPHA picks lead or trail as sample edge.
      for (int m = 0; m < 4; m++) begin
        cpol = (m >= 2);
        nsck = bus.idle ? cpol : (cpol ^ bus.M_BaudRate);
        if (nsck !== sck[m]) begin
          if (nsck !== cpol) lead[m]++;
          else trail[m]++;
        end
        sck[m] = nsck;
        if (r == p) begin
          checks++;
          if (lead[m] != B || trail[m] != B || sck[m] !== cpol) begin
            failures++;
            $display("FAIL %s_sck mode=%0d got lead=%0d trail=%0d sck=%b exp lead=%0d trail=%0d sck=%b",
                     nm, m, lead[m], trail[m], sck[m], B, B, cpol);
          end
          lead[m]  = 0;
          trail[m] = 0;
        end
      end
      if (inj != 0 && rel == inj) begin
        bus.start   = 1'b1;
        bus.clk_div = DW'(5);
      end
      if (inj != 0 && rel == inj + 3) bus.start = 1'b0;
      if (hold && rel == total) bus.start = 1'b0;
    end
    checks++;
    if (ndone != nfr) begin
      failures++;
      $display("FAIL %s_done_count got=%0d exp=%0d", nm, ndone, nfr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (act_vec() !== idle_vec(0)) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", act_vec(), idle_vec(0));
    end
    rst = 1'b0;
  endtask

  task automatic test_frame_d1();
    frame_run(1, 1, 1'b0, 0, "frame_d1");
  endtask

  task automatic test_frame_d0();
    frame_run(0, 1, 1'b0, 0, "frame_d0");
  endtask

  task automatic test_busy_ignore();
    frame_run(1, 1, 1'b0, 10, "busy_ignore");
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] exp;
    @(posedge clk); #1;
    bus.clk_div = DW'(1);
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int rel = 1; rel <= 10; rel++) begin
      @(negedge clk);
      exp = model(rel, 2);
      checks++;
      if (act_vec() !== exp) begin
        failures++;
        $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", rel, act_vec(), exp);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int rel = 11; rel <= 50; rel++) begin
      checks++;
      if (act_vec() !== idle_vec(0)) begin
        failures++;
        $display("FAIL rst_mid cyc=%0d got=%b exp=%b", rel, act_vec(), idle_vec(0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    frame_run(int'($urandom_range(0, 2)), 3, 1'b1, 0, "back_to_back");
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      frame_run(int'($urandom_range(0, 4)), int'($urandom_range(1, 2)),
                1'b1, 0, "random");
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.clk_div = '0;
    test_reset();
    test_frame_d1();
    test_frame_d0();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
